// File: rtl/rv32_mem_ops.sv
// Shared definitions for the rv32 data-memory responder: FSM state encoding,
// legal byte-enable patterns and the mask legality helper.
package rv32_mem_ops;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  // Byte lane for offset 0; the lane for offset n is this shifted right by n.
  localparam logic [3:0] MASK_BYTE    = 4'b1000;

  function automatic logic mask_legal(input logic [1:0] off, input logic [3:0] mask);
    logic ok;
    ok = (mask == (MASK_BYTE >> off));
    if (off == 2'b00) ok = ok | (mask == MASK_WORD) | (mask == MASK_HALF_HI);
    if (off == 2'b10) ok = ok | (mask == MASK_HALF_LO);
    return ok;
  endfunction

endpackage

// File: rtl/rv32_dmem_check.sv
// Combinational range and alignment checker for rv32_dmem requests.
module rv32_dmem_check
  import rv32_mem_ops::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic [31:0] addr_i,
  input  logic [3:0]  mask_i,
  input  logic        write_i,
  output logic        fault_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic out_of_range;
  logic bad_mask;
  logic empty_store;

  assign out_of_range = |(addr_i >> (AW + 2));
  assign bad_mask     = !mask_legal(addr_i[1:0], mask_i);
  assign empty_store  = write_i && (mask_i == 4'b0000);
  assign fault_o      = out_of_range | bad_mask | empty_store;

endmodule

// File: rtl/rv32_dmem.sv
// Single-port data-memory responder with fixed wait states and valid/ready
// request/response handshakes. Define RV32_DMEM_FAULT_EN to enable fault checks.
module rv32_dmem
  import rv32_mem_ops::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [3:0]  req_mask_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] resp_rdata_out,
  output logic        resp_fault_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          access;
  logic          access_fault;
  logic          mem_we;

  assign idx = addr_q[AW+1:2];

`ifdef RV32_DMEM_FAULT_EN
  rv32_dmem_check #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_check (
    .addr_i (addr_q),
    .mask_i (mask_q),
    .write_i(write_q),
    .fault_o(access_fault)
  );
`else
  // Upper address bits and the byte offset are ignored, so addresses wrap.
  logic unused_addr;
  assign unused_addr  = ^{addr_q[31:AW+2], addr_q[1:0]};
  assign access_fault = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          write_d = req_write_in;
          addr_d  = req_addr_in;
          wdata_d = req_wdata_in;
          mask_d  = req_mask_in;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          fault_d = access_fault;
          rdata_d = (write_q || access_fault) ? 32'd0 : mem_q[idx];
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we = access & write_q & ~access_fault;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; a pending store is
  // dropped on reset because state_q leaves BUSY asynchronously.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready_out  = (state_q == ST_IDLE);
  assign resp_valid_out = (state_q == ST_RESP);
  assign resp_rdata_out = rdata_q;
  assign resp_fault_out = fault_q;

endmodule

// File: tb/tb_rv32_dmem.sv
// Directed self-checking bench for rv32_dmem (DEPTH_WORDS=256, WAIT_STATES=1);
// fault-specific vectors follow RV32_DMEM_FAULT_EN.
module tb_rv32_dmem;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_mask_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_fault_out;

  int n_checks = 0;
  int n_errors = 0;

  rv32_dmem #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_write_in  (req_write_in),
    .req_addr_in   (req_addr_in),
    .req_wdata_in  (req_wdata_in),
    .req_mask_in   (req_mask_in),
    .resp_valid_out(resp_valid_out),
    .resp_ready_in (resp_ready_in),
    .resp_rdata_out(resp_rdata_out),
    .resp_fault_out(resp_fault_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; inputs are scrambled after the accepting edge to
  // prove the responder works from its captured copy.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_fault);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, req_ready_out}, 32'd1);
    req_valid_in = 1'b1;
    req_write_in = wr;
    req_addr_in  = addr;
    req_wdata_in = wdata;
    req_mask_in  = mask;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    req_write_in = ~wr;
    req_addr_in  = 32'hFFFF_FFFF;
    req_wdata_in = 32'h5A5A_5A5A;
    req_mask_in  = 4'b0110;
    n = 0;
    while (!resp_valid_out && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, WS + 1);
    check({tag, "_rdata"}, resp_rdata_out, exp_rdata);
    check({tag, "_fault"}, {31'd0, resp_fault_out}, {31'd0, exp_fault});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {31'd0, resp_valid_out}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata_out, exp_rdata);
      check({tag, "_hold_rdy"}, {31'd0, req_ready_out}, 32'd0);
    end
    resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_in = 1'b0;
    check({tag, "_done_valid"}, {31'd0, resp_valid_out}, 32'd0);
    check({tag, "_done_rdy"}, {31'd0, req_ready_out}, 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid_in  = 1'b0;
    req_write_in  = 1'b0;
    req_addr_in   = '0;
    req_wdata_in  = '0;
    req_mask_in   = '0;
    resp_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, resp_valid_out}, 32'd0);
    check("rst_rdy",   {31'd0, req_ready_out},  32'd1);
    check("rst_rdata", resp_rdata_out,          32'd0);
    check("rst_fault", {31'd0, resp_fault_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_req("st_word",  1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0,         1'b0);
    do_req("ld_word",  1'b0, 32'h10, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, 1'b0);
    do_req("st_byte3", 1'b1, 32'h13, 32'h0000_00AB, 4'b0001, 0, 32'h0,         1'b0);
    do_req("ld_hold",  1'b0, 32'h10, 32'h0,         4'b1111, 5, 32'hDEAD_BEAB, 1'b0);

`ifdef RV32_DMEM_FAULT_EN
    do_req("st_misal", 1'b1, 32'h12,  32'h0102_0304, 4'b1111, 0, 32'h0,         1'b1);
    do_req("ld_after", 1'b0, 32'h10,  32'h0,         4'b1111, 0, 32'hDEAD_BEAB, 1'b0);
    do_req("ld_range", 1'b0, 32'h400, 32'h0,         4'b1111, 0, 32'h0,         1'b1);
    do_req("st_empty", 1'b1, 32'h10,  32'hFFFF_FFFF, 4'b0000, 0, 32'h0,         1'b1);
`else
    do_req("st_wrap",  1'b1, 32'h400, 32'h1122_3344, 4'b1111, 0, 32'h0,         1'b0);
    do_req("ld_wrap",  1'b0, 32'h000, 32'h0,         4'b1111, 0, 32'h1122_3344, 1'b0);
`endif

    do_req("st_half",  1'b1, 32'h12, 32'h0000_CCDD, 4'b0011, 0, 32'h0,         1'b0);
    do_req("ld_half",  1'b0, 32'h10, 32'h0,         4'b1111, 0, 32'hDEAD_CCDD, 1'b0);

    do_req("st_pre",   1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 0, 32'h0,         1'b0);
    @(negedge clk);
    req_valid_in = 1'b1;
    req_write_in = 1'b1;
    req_addr_in  = 32'h20;
    req_wdata_in = 32'h5555_5555;
    req_mask_in  = 4'b1111;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("rstb_rdy",   {31'd0, req_ready_out},  32'd1);
    check("rstb_valid", {31'd0, resp_valid_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rstb_noresp", {31'd0, resp_valid_out}, 32'd0);
    end
    do_req("ld_rstb",  1'b0, 32'h20, 32'h0,         4'b1111, 0, 32'hCAFE_F00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_dmem.md
# rv32_dmem

Single-port data-memory responder serving the load/store requests issued by the pipeline memory stage. Accepts one request at a time over a valid/ready handshake and waits a fixed number of cycles. It then performs a byte-masked write or a full-word read and returns the result over a second valid/ready handshake. It moves storage out of the pipeline stage so that wait states and faults are modelled explicitly.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 1: extra cycles between accept and access; range 0..15.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_in  in  1  request present
- req_ready_out  out  1  responder can accept a request
- req_write_in  in  1  1 = store, 0 = load
- req_addr_in  in  32  byte address
- req_wdata_in  in  32  store data, lane-aligned: byte offset 0 in [31:24], offset 3 in [7:0]
- req_mask_in  in  4  byte enables; bit 3 = [31:24], bit 0 = [7:0]
- resp_valid_out  out  1  response present
- resp_ready_in  in  1  requester accepts response
- resp_rdata_out  out  32  full word read; 0 for stores and faults
- resp_fault_out  out  1  request rejected (see Configuration)

## Operation
- States: IDLE, BUSY, RESP. req_ready_out = (state == IDLE), combinational from state only.
- IDLE: on req_valid_in high at a posedge, capture write, addr, wdata and mask. Load counter with WAIT_STATES and go to BUSY. The requester may change its inputs after the accepting edge.
- BUSY, counter != 0: decrement the counter.
- BUSY, counter == 0:
  - Perform the access using the captured fields.
  - Register rdata and fault, then go to RESP.
- Index is addr[log2(DEPTH_WORDS)+1:2].
- Store: only the lanes with a set mask bit are written. resp_rdata_out = 0.
- Load: the whole word is returned; the mask is ignored for data. Lane extraction and sign extension belong to the requester.
- RESP: resp_valid_out = 1. rdata and fault stay stable until resp_valid_out and resp_ready_in are both high at a posedge, then go to IDLE.
- No overlap: a new request cannot be accepted in the cycle its predecessor's response completes.
- Reset: state IDLE, counter 0, resp_valid_out 0, resp_rdata_out 0, resp_fault_out 0. Memory contents are not reset.
- A store still in BUSY when reset asserts is never written, and any pending response is discarded.

## Timing
- Accept at edge E0 → resp_valid_out high after edge E0+WAIT_STATES+1.
- The array is written at that same edge.
- Earliest response handshake is E0+WAIT_STATES+2; earliest next accept is E0+WAIT_STATES+3.
- WAIT_STATES = 0: BUSY lasts exactly one cycle.
- Read-after-write to the same word with back-to-back requests returns the newly written data.

## Configuration
- RV32_DMEM_FAULT_EN defined:
  - Fault when any address bit above the index is nonzero (out of range).
  - Fault when the mask is not one of the legal masks for addr[1:0]:
    - 1111 at 00
    - 1100 at 00
    - 0011 at 10
    - single bit (3 - offset) at any offset
  - Fault when a store has an all-zero mask.
  - On fault: no array write, resp_rdata_out = 0, resp_fault_out = 1. Latency is unchanged.
- RV32_DMEM_FAULT_EN undefined:
  - resp_fault_out tied 0.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - The mask is applied as given, with no legality check.

## Structure
- Shared constants in rv32_mem_ops.sv: state encoding (IDLE/BUSY/RESP) and the legal mask constants (word, upper half, lower half, byte lanes).
- Sub-module rv32_dmem_check: combinational range and alignment checker taking addr, mask and write, producing fault. Instantiated only under RV32_DMEM_FAULT_EN.

## Test plan
- Reset, then WAIT_STATES=1: store 0xDEADBEEF mask 1111 at 0x10, then load 0x10 → rdata 0xDEADBEEF, fault 0. resp_valid_out rises 2 edges after each accept.
- Store 0x000000AB mask 0001 at 0x13 over the previous word, then load 0x10 → 0xDEADBEAB.
- Hold resp_ready_in low 5 cycles → resp_valid_out and rdata held stable, req_ready_out 0 throughout. Then release and check req_ready_out rises the following cycle.
- With FAULT_EN: store mask 1111 at 0x12 → fault 1 and word 0x10 unchanged. Load at 0x400 with depth 256 → fault 1, rdata 0.
- Without FAULT_EN: store 0x11223344 at 0x400, then load 0x000 → 0x11223344.
- Assert reset_n low during BUSY of a store to 0x20 → no response issued, and a later load of 0x20 returns the prior contents.
